sha256_round_ctrl: RTL

Iterative SHA-256 compression controller. It sequences one 512-bit message block through 64 rounds of a single-round datapath, one round per clock, then performs the final chaining addition. It owns the round counter, the 16-word message-schedule window, the working registers a..h, the K-constant selection and a start/valid handshake. It sits between the bus-side message/digest registers and the combinational round logic, and replaces a fully unrolled compression function.

---
 rtl/sha256_pkg.sv | 69 ++++++
 rtl/sha256_round_step.sv | 29 ++
 rtl/sha256_round_ctrl.sv | 116 +++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// SHA-256 constants, round functions and controller state encoding.
package sha256_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_FINAL = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Field order matches the bus layout: a/H0 occupies the top word.
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
    logic [31:0] e;
    logic [31:0] f;
    logic [31:0] g;
    logic [31:0] h;
  } work_t;

  localparam logic [255:0] H_INIT = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K_TAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/sha256_round_step.sv
// One combinational SHA-256 round: next a..h from current a..h, K[t] and W[t].
module sha256_round_step
  import sha256_pkg::*;
(
  input  work_t       i_work,
  input  logic [31:0] i_k,
  input  logic [31:0] i_w,
  output work_t       o_work
);

  logic [31:0] w_t1;
  logic [31:0] w_t2;

  assign w_t1 = i_work.h + big_sigma1(i_work.e) + ch(i_work.e, i_work.f, i_work.g) + i_k + i_w;
  assign w_t2 = big_sigma0(i_work.a) + maj(i_work.a, i_work.b, i_work.c);

  always_comb begin
    o_work   = i_work;
    o_work.a = w_t1 + w_t2;
    o_work.b = i_work.a;
    o_work.c = i_work.b;
    o_work.d = i_work.c;
    o_work.e = i_work.d + w_t1;
    o_work.f = i_work.e;
    o_work.g = i_work.f;
    o_work.h = i_work.g;
  end

endmodule

// File: rtl/sha256_round_ctrl.sv
// Iterative SHA-256 compression: one round per clock, 66 cycles start-to-valid.
// Starts are accepted only while ready; abort drops an in-flight block silently.
module sha256_round_ctrl
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         init,
  input  logic [255:0] digest_in,
  input  logic [511:0] block_in,
  input  logic         abort,
  output logic         ready,
  output logic         busy,
  output logic         valid,
  output logic [255:0] digest_out,
  output logic [5:0]   round_idx
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [5:0]         r_t;
  work_t              r_work;
  work_t              w_work_nxt;
  logic [255:0]       w_work_flat;
  logic [255:0]       r_hold;
  logic [255:0]       r_digest;
  logic [15:0][31:0]  r_win;
  logic [31:0]        w_sched;
  logic [255:0]       w_chain;
  logic [255:0]       w_sum;

  assign w_chain     = init ? H_INIT : digest_in;
  assign w_work_flat = r_work;

  // r_win[15] is W[t]; r_win[15-j] is W[t+j], so this produces W[t+16].
  assign w_sched = small_sigma1(r_win[1]) + r_win[6] + small_sigma0(r_win[14]) + r_win[15];

  sha256_round_step u_step (
    .i_work (r_work),
    .i_k    (K_TAB[r_t]),
    .i_w    (r_win[15]),
    .o_work (w_work_nxt)
  );

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < 8; i++) begin
      w_sum[i*32 +: 32] = r_hold[i*32 +: 32] + w_work_flat[i*32 +: 32];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_ROUND;
      S_ROUND: begin
        if (abort)             w_state_nxt = S_IDLE;
        else if (r_t == 6'd63) w_state_nxt = S_FINAL;
      end
      S_FINAL: w_state_nxt = abort ? S_IDLE : S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ready     = (r_state == S_IDLE);
    busy      = (r_state == S_ROUND) || (r_state == S_FINAL);
    valid     = (r_state == S_DONE);
    round_idx = (r_state == S_ROUND) ? r_t : 6'd0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_t      <= '0;
      r_work   <= '0;
      r_hold   <= '0;
      r_win    <= '0;
      r_digest <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_hold <= w_chain;
            r_work <= w_chain;
            r_win  <= block_in;
            r_t    <= '0;
          end
        end
        S_ROUND: begin
          if (!abort) begin
            r_work <= w_work_nxt;
            r_win  <= {r_win[14:0], w_sched};
            r_t    <= r_t + 6'd1;
          end
        end
        S_FINAL: begin
          if (!abort) r_digest <= w_sum;
        end
        default: ;
      endcase
    end
  end

  assign digest_out = r_digest;

endmodule
